// File: rtl/pipe_pkg.sv
// Shared pipeline types: forward select codes, stage record, widths.
package pipe_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned MD_CW  = 6;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] wa;
    logic              we;
    logic              load;
  } stage_rec_t;

  localparam stage_rec_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard inputs and stall/flush/forward outputs of the hazard controller.
interface hazard_ctrl_if;
  import pipe_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic [REG_AW-1:0] id_wa;
  logic              id_we;
  logic              id_is_load;
  logic              id_uses_hilo;
  logic              id_start_md;
  logic              id_md_div;
  logic              ex_branch_taken;
  logic              stall_if_id;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              md_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wa, id_we,
           id_is_load, id_uses_hilo, id_start_md, id_md_div, ex_branch_taken,
    input  stall_if_id, flush_if_id, flush_id_ex, fwd_a, fwd_b, md_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wa, id_we,
           id_is_load, id_uses_hilo, id_start_md, id_md_div, ex_branch_taken,
    output stall_if_id, flush_if_id, flush_id_ex, fwd_a, fwd_b, md_busy
  );

endinterface

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Down-counter that tracks how long the mult/div unit stays busy.
module md_busy_counter
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MD_CW-1:0] cycles,
  output logic             busy_c
);

  logic [MD_CW-1:0] cnt;

  // Load on start, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= cycles;
    end else if (cnt != '0) begin
      cnt <= cnt - MD_CW'(1);
    end
  end

  assign busy_c = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO stalls, branch flushes,
// operand forwarding from shadow EX/MEM/WB destination records.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  stage_rec_t       ex_r;
  stage_rec_t       mem_r;
  stage_rec_t       wb_r;
  stage_rec_t       id_rec_c;
  logic             lu_c;
  logic             hl_c;
  logic             stall_c;
  logic             issue_c;
  logic             md_start_c;
  logic [MD_CW-1:0] md_cycles_c;
  logic             md_busy_c;
  fwd_e             fwd_a_c;
  fwd_e             fwd_b_c;

  // A stage produces a usable value for r; register 0 never matches.
  function automatic logic hit(stage_rec_t s, logic [REG_AW-1:0] r);
    return s.valid & s.we & (s.wa == r) & (r != '0);
  endfunction

  // Youngest producer wins; unused operands always read the regfile.
  function automatic fwd_e fwd_sel(logic used, logic [REG_AW-1:0] r,
                                   stage_rec_t ex, stage_rec_t mem, stage_rec_t wb);
    fwd_e sel;
    sel = FWD_REG;
    if (used) begin
      if (hit(ex, r))       sel = FWD_EX;
      else if (hit(mem, r)) sel = FWD_MEM;
      else if (hit(wb, r))  sel = FWD_WB;
    end
    return sel;
  endfunction

  // Stall, issue and forward decisions from current records and decode inputs.
  always_comb begin
    lu_c        = 1'b0;
    hl_c        = 1'b0;
    stall_c     = 1'b0;
    issue_c     = 1'b0;
    md_start_c  = 1'b0;
    md_cycles_c = MD_CW'(MUL_CYCLES);
    id_rec_c    = STAGE_BUBBLE;
    fwd_a_c     = FWD_REG;
    fwd_b_c     = FWD_REG;

    lu_c = hz.id_valid & ex_r.load &
           ((hz.id_rs_used & hit(ex_r, hz.id_rs)) |
            (hz.id_rt_used & hit(ex_r, hz.id_rt)));
    hl_c = hz.id_valid & md_busy_c & (hz.id_uses_hilo | hz.id_start_md);
    // A taken branch squashes the decode instruction, so stalling it is moot.
    stall_c = (lu_c | hl_c) & ~hz.ex_branch_taken;
    issue_c = hz.id_valid & ~stall_c & ~hz.ex_branch_taken;

    md_start_c  = issue_c & hz.id_start_md;
    md_cycles_c = hz.id_md_div ? MD_CW'(DIV_CYCLES) : MD_CW'(MUL_CYCLES);

    id_rec_c.valid = 1'b1;
    id_rec_c.wa    = hz.id_wa;
    id_rec_c.we    = hz.id_we;
    id_rec_c.load  = hz.id_is_load;

    fwd_a_c = fwd_sel(hz.id_rs_used, hz.id_rs, ex_r, mem_r, wb_r);
    fwd_b_c = fwd_sel(hz.id_rt_used, hz.id_rt, ex_r, mem_r, wb_r);
  end

  // Shadow destination records advance every cycle; EX takes a bubble unless ID issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_r  <= STAGE_BUBBLE;
      mem_r <= STAGE_BUBBLE;
      wb_r  <= STAGE_BUBBLE;
    end else begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      ex_r  <= issue_c ? id_rec_c : STAGE_BUBBLE;
    end
  end

  md_busy_counter u_md_busy_counter (
    .clk    (clk),
    .rst_n  (rst),
    .start  (md_start_c),
    .cycles (md_cycles_c),
    .busy_c (md_busy_c)
  );

  assign hz.stall_if_id = stall_c;
  assign hz.flush_if_id = hz.ex_branch_taken;
  assign hz.flush_id_ex = stall_c | hz.ex_branch_taken;
  assign hz.fwd_a       = 2'(fwd_a_c);
  assign hz.fwd_b       = 2'(fwd_b_c);
  assign hz.md_busy     = md_busy_c;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed instruction streams with a
// scoreboard of hand-derived expected outputs per decode cycle.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsu;
    logic       rtu;
    logic [4:0] wa;
    logic       we;
    logic       ld;
    logic       hilo;
    logic       md;
    logic       dv;
    logic       br;
  } ins_t;

  typedef struct {
    logic       st;
    logic       fi;
    logic       fe;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       busy;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  hazard_ctrl_if hz ();

  hazard_ctrl #(
    .MUL_CYCLES (4),
    .DIV_CYCLES (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic ins_t nop();
    ins_t i;
    i = '{default: '0};
    return i;
  endfunction

  function automatic ins_t op(logic [4:0] rs, logic rsu, logic [4:0] rt, logic rtu,
                              logic [4:0] wa, logic we);
    ins_t i;
    i     = nop();
    i.v   = 1'b1;
    i.rs  = rs;
    i.rsu = rsu;
    i.rt  = rt;
    i.rtu = rtu;
    i.wa  = wa;
    i.we  = we;
    return i;
  endfunction

  function automatic exp_t ex(logic st, logic fi, logic fe, logic [1:0] fa,
                              logic [1:0] fb, logic busy);
    exp_t e;
    e.st = st; e.fi = fi; e.fe = fe; e.fa = fa; e.fb = fb; e.busy = busy;
    return e;
  endfunction

  task automatic apply(input ins_t i);
    hz.id_valid        = i.v;
    hz.id_rs           = i.rs;
    hz.id_rt           = i.rt;
    hz.id_rs_used      = i.rsu;
    hz.id_rt_used      = i.rtu;
    hz.id_wa           = i.wa;
    hz.id_we           = i.we;
    hz.id_is_load      = i.ld;
    hz.id_uses_hilo    = i.hilo;
    hz.id_start_md     = i.md;
    hz.id_md_div       = i.dv;
    hz.ex_branch_taken = i.br;
  endtask

  // One decode cycle: drive after the edge, queue the expectation, compare mid-cycle.
  task automatic step(input string tag, input ins_t i, input exp_t e);
    exp_t  o;
    string tg;
    @(posedge clk);
    #1;
    apply(i);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    o  = exp_q.pop_front();
    tg = tag_q.pop_front();
    chk({tg, ".stall"},  8'(hz.stall_if_id), 8'(o.st));
    chk({tg, ".fl_ifid"}, 8'(hz.flush_if_id), 8'(o.fi));
    chk({tg, ".fl_idex"}, 8'(hz.flush_id_ex), 8'(o.fe));
    chk({tg, ".fwd_a"},  8'(hz.fwd_a),       8'(o.fa));
    chk({tg, ".fwd_b"},  8'(hz.fwd_b),       8'(o.fb));
    chk({tg, ".busy"},   8'(hz.md_busy),     8'(o.busy));
  endtask

  task automatic nops(input int n, input logic busy);
    for (int k = 0; k < n; k++) step("nop", nop(), ex(0, 0, 0, 0, 0, busy));
  endtask

  initial begin
    ins_t i;
    exp_t z;
    z = ex(0, 0, 0, 0, 0, 0);
    apply(nop());

    // Reset state
    step("rst", op(1, 1, 2, 1, 3, 1), z);
    apply(nop());
    rst = 1'b1;

    // ALU chain forwarding EX -> MEM -> WB
    step("alu0", op(1, 1, 2, 1, 3, 1), z);
    step("alu1", op(3, 1, 3, 1, 4, 1), ex(0, 0, 0, 1, 1, 0));
    step("alu2", op(3, 1, 3, 0, 5, 1), ex(0, 0, 0, 2, 0, 0));
    step("alu3", op(3, 1, 0, 0, 6, 1), ex(0, 0, 0, 3, 0, 0));
    nops(3, 0);

    // Load-use: one bubble then MEM forward
    i = op(1, 1, 5, 0, 5, 1); i.ld = 1'b1;
    step("lw", i, z);
    step("lu0", op(5, 1, 0, 1, 6, 1), ex(1, 0, 1, 1, 0, 0));
    step("lu1", op(5, 1, 0, 1, 6, 1), ex(0, 0, 0, 2, 0, 0));
    nops(3, 0);

    // Register 0 never forwards or stalls
    i = op(1, 1, 0, 0, 0, 1); i.ld = 1'b1;
    step("lw0", i, z);
    step("r0", op(0, 1, 0, 1, 11, 1), z);
    nops(3, 0);

    // div then mflo: held exactly DIV_CYCLES, issues as busy falls
    i = op(1, 1, 2, 1, 0, 0); i.md = 1'b1; i.dv = 1'b1;
    step("div", i, z);
    i = op(0, 0, 0, 0, 7, 1); i.hilo = 1'b1;
    for (int k = 0; k < 32; k++) step("mflo_wait", i, ex(1, 0, 1, 0, 0, 1));
    step("mflo_go", i, z);
    step("use_lo", op(7, 1, 0, 0, 8, 1), ex(0, 0, 0, 1, 0, 0));

    // mult busy window
    i = op(1, 1, 2, 1, 0, 0); i.md = 1'b1;
    step("mult", i, z);
    nops(4, 1);
    nops(1, 0);

    // Branch in EX suppresses md issue
    i = op(1, 1, 2, 1, 0, 0); i.md = 1'b1; i.br = 1'b1;
    step("mult_br", i, ex(0, 1, 1, 0, 0, 0));
    nops(2, 0);

    // Load-use overridden by taken branch; squashed instruction leaves a bubble
    i = op(1, 1, 5, 0, 5, 1); i.ld = 1'b1;
    step("lw_b", i, z);
    i = op(5, 1, 0, 1, 6, 1); i.br = 1'b1;
    step("lu_br", i, ex(0, 1, 1, 1, 0, 0));
    step("post_br", op(6, 1, 5, 1, 10, 1), ex(0, 0, 0, 0, 2, 0));
    nops(3, 0);

    // Reset mid-divide with records valid
    i = op(1, 1, 2, 1, 0, 0); i.md = 1'b1; i.dv = 1'b1;
    step("div2", i, z);
    for (int k = 0; k < 12; k++) step("div_run", op(0, 0, 0, 0, 9, 1), ex(0, 0, 0, 0, 0, 1));
    @(posedge clk);
    #1;
    apply(op(9, 1, 9, 1, 0, 0));
    #1;
    chk("pre_rst.fwd_a", 8'(hz.fwd_a), 8'd1);
    chk("pre_rst.busy", 8'(hz.md_busy), 8'd1);
    rst = 1'b0;
    #1;
    chk("in_rst.busy", 8'(hz.md_busy), 8'd0);
    chk("in_rst.fwd_a", 8'(hz.fwd_a), 8'd0);
    chk("in_rst.fwd_b", 8'(hz.fwd_b), 8'd0);
    chk("in_rst.stall", 8'(hz.stall_if_id), 8'd0);
    @(negedge clk);
    apply(nop());
    rst = 1'b1;
    step("post_rst", op(9, 1, 9, 1, 0, 0), z);

    if (exp_q.size() != 0) chk("queue_drain", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It watches the decode-stage instruction (source registers, write-back address, load/HI-LO/mult-div class) and keeps its own shadow copy of the EX, MEM and WB stage destinations. From these it drives stall, flush and operand-forwarding selects. It also sequences the multi-cycle multiply/divide unit with a busy counter that guards HI/LO access.

## Interface
Parameters:
- `MUL_CYCLES`, default 4: busy cycles after a mult issue (1..63)
- `DIV_CYCLES`, default 32: busy cycles after a div issue (1..63)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  decode stage holds a valid instruction
- `id_rs`, `id_rt`  in  5  source register numbers
- `id_rs_used`, `id_rt_used`  in  1  the instruction actually reads rs / rt
- `id_wa`  in  5  write address (output of the regwa mux)
- `id_we`  in  1  register write enable
- `id_is_load`  in  1  write data comes from memory
- `id_uses_hilo`  in  1  instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo)
- `id_start_md`  in  1  instruction is mult/multu/div/divu
- `id_md_div`  in  1  with `id_start_md`: 1 = divide, 0 = multiply
- `ex_branch_taken`  in  1  branch/jump resolved taken in EX
- `stall_if_id`  out  1  hold PC and the IF/ID register
- `flush_if_id`  out  1  squash the IF/ID register
- `flush_id_ex`  out  1  load a bubble into ID/EX
- `fwd_a`, `fwd_b`  out  2  operand select for rs / rt: 0 regfile, 1 EX result, 2 MEM result, 3 WB data
- `md_busy`  out  1  mult/div unit running

## Operation
- Stage records `ex_r`, `mem_r`, `wb_r`, each {valid, wa[4:0], we, load}, advance every cycle: wb_r<=mem_r, mem_r<=ex_r.
- `ex_r` loads the ID record when `issue` = id_valid & !stall_if_id & !ex_branch_taken. Otherwise it loads a bubble (valid=0).
- `hit(S,r)`: S.valid & S.we & S.wa==r & r!=0. Register 0 never forwards and never stalls.
- Load-use stall: `lu` = id_valid & ((id_rs_used & hit(ex_r,id_rs) & ex_r.load) | (id_rt_used & hit(ex_r,id_rt) & ex_r.load)).
- HI/LO stall: `hl` = id_valid & md_busy & (id_uses_hilo | id_start_md).
- stall_if_id = (lu | hl) & !ex_branch_taken.
- flush_if_id = ex_branch_taken.
- flush_id_ex = stall_if_id | ex_branch_taken.
- Forward select for operand a (b identical with rt):
  - 1 if hit(ex_r,rs);
  - else 2 if hit(mem_r,rs);
  - else 3 if hit(wb_r,rs);
  - else 0.
  - Gated to 0 when the operand is unused.
  - Priority is EX > MEM > WB (youngest wins).
- Mult/div counter `md_cnt` (6 bits):
  - On issue & id_start_md, load DIV_CYCLES or MUL_CYCLES.
  - Else decrement if nonzero.
  - md_busy = (md_cnt != 0).
- Simultaneous events:
  - Branch taken overrides stall: no stall, both flushes asserted, no md issue.
  - A stalled md instruction does not load the counter.
  - When the counter reaches 0 in cycle n, a waiting HI/LO instruction issues in cycle n.

## Timing
- All outputs are combinational from registered state plus same-cycle ID/EX inputs. There is no added latency.
- State updates on the rising edge of `clk`.
- Load-use costs exactly one bubble. In the following cycle the load sits in MEM and forwards with select 2.
- A mult issued at edge k gives md_busy high for cycles k+1 .. k+MUL_CYCLES.
- Reset (`rst` low, asynchronous, at any time including mid-divide):
  - All records invalid, md_cnt=0.
  - Outputs: stall_if_id=0, flush_if_id=0, flush_id_ex=0, fwd_a=0, fwd_b=0, md_busy=0.
  - Release is synchronous to the next `clk` edge.

## Structure
- Shared package `pipe_pkg`:
  - forward codes FWD_REG=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3;
  - stage record typedef `stage_rec_t`;
  - register-address width constant 5.
- One sub-module, `md_busy_counter`:
  - loads the cycle count on start;
  - counts down to 0;
  - outputs busy.
- Hit comparison and forward selection stay inline, one function used for both operands.

## Test plan
- Reset mid-div with md_cnt=20 → md_busy=0 immediately; all records cleared; fwd_a=fwd_b=0.
- `addu $3,$1,$2` then `subu $4,$3,$3` → fwd_a=fwd_b=1, no stall; third instruction reading $3 → select 2, then 3 one cycle later.
- `lw $5,0($1)` then `addu $6,$5,$0`:
  - cycle 1: stall_if_id=1, flush_id_ex=1;
  - cycle 2: stall=0, fwd_a=2.
- Write to $0 in EX, next instruction reads $0 → fwd_a=0, stall=0.
- `div` (DIV_CYCLES=32) then `mflo` → stall held exactly 32 cycles; mflo issues on the cycle md_busy falls.
- Load-use stall with ex_branch_taken=1 in the same cycle → stall_if_id=0, flush_if_id=1, flush_id_ex=1; ex_r becomes a bubble.
